// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file: FSM state,
// constant clog2 and the byte-lane merge used by regfile_be_merge.
package regfile_pkg;

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam int MERGE_MAX_W  = 1024;
   localparam int MERGE_MAX_BE = MERGE_MAX_W / 8;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 << i) < n) begin
            r = i + 1;
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   // Operates at the widest supported width; callers extend and truncate.
   function automatic logic [MERGE_MAX_W-1:0] merge_be(
      input logic [MERGE_MAX_W-1:0]  old_data,
      input logic [MERGE_MAX_W-1:0]  new_data,
      input logic [MERGE_MAX_BE-1:0] be
   );
      logic [MERGE_MAX_W-1:0] res;
      res = old_data;
      for (int i = 0; i < MERGE_MAX_BE; i++) begin
         if (be[i]) begin
            res[8*i +: 8] = new_data[8*i +: 8];
         end else begin
            res[8*i +: 8] = old_data[8*i +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Register file access bus: NRD read ports, one byte-enabled write port, ready.
interface regfile_mp_if
   import regfile_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter int NRD      = 2
);
   localparam int AW   = clog2(NUM_REGS);
   localparam int BE_W = DATA_W / 8;

   logic [NRD-1:0]        rd_en;
   logic [NRD*AW-1:0]     rd_addr;
   logic [NRD*DATA_W-1:0] rd_data;
   logic                  wr_en;
   logic [AW-1:0]         wr_addr;
   logic [DATA_W-1:0]     wr_data;
   logic [BE_W-1:0]       wr_be;
   logic                  ready;

   modport master (
      output rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_be,
      input  rd_data, ready
   );

   modport slave (
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_be,
      output rd_data, ready
   );
endinterface

// File: rtl/regfile_be_merge.sv
// Byte-lane merge: written lanes take new_data, the rest keep old_data.
module regfile_be_merge
   import regfile_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]   old_data,
   input  logic [DATA_W-1:0]   new_data,
   input  logic [DATA_W/8-1:0] be,
   output logic [DATA_W-1:0]   merged
);
   assign merged = DATA_W'(merge_be(MERGE_MAX_W'(old_data),
                                    MERGE_MAX_W'(new_data),
                                    MERGE_MAX_BE'(be)));
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with hardware clear after reset and byte-enabled writes.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to matching reads.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter int NRD      = 2
) (
   input logic          clk,
   input logic          rst,
   regfile_mp_if.slave  bus
);
   localparam int AW = clog2(NUM_REGS);

   state_e                state_r;
   logic [AW-1:0]         clr_idx_r;
   logic [DATA_W-1:0]     regs_r [NUM_REGS];
   logic [NRD*DATA_W-1:0] rd_data_r;
   logic                  ready_r;

   logic                  wr_addr_ok_s;
   logic                  wr_hit_s;
   logic [DATA_W-1:0]     wr_old_s;
   logic [DATA_W-1:0]     wr_merged_s;
   logic [AW-1:0]         rd_addr_s [NRD];
   logic [DATA_W-1:0]     rd_val_s  [NRD];

   // The merged word serves both the array write and the read bypass.
   regfile_be_merge #(.DATA_W(DATA_W)) u_merge (
      .old_data (wr_old_s),
      .new_data (bus.wr_data),
      .be       (bus.wr_be),
      .merged   (wr_merged_s)
   );

   // Write qualification and per-port read value selection.
   always_comb begin
      wr_addr_ok_s = ({1'b0, bus.wr_addr} < (AW+1)'(NUM_REGS)) &&
                     (bus.wr_addr != {AW{1'b0}});
      wr_old_s     = wr_addr_ok_s ? regs_r[bus.wr_addr] : {DATA_W{1'b0}};
      wr_hit_s     = (state_r == RUN) && bus.wr_en && wr_addr_ok_s;
      for (int p = 0; p < NRD; p++) begin
         rd_addr_s[p] = bus.rd_addr[p*AW +: AW];
         if (({1'b0, rd_addr_s[p]} < (AW+1)'(NUM_REGS)) &&
             (rd_addr_s[p] != {AW{1'b0}})) begin
            rd_val_s[p] = regs_r[rd_addr_s[p]];
         end else begin
            rd_val_s[p] = {DATA_W{1'b0}};
         end
`ifdef REGFILE_BYPASS_EN
         rd_val_s[p] = (wr_hit_s && (rd_addr_s[p] == bus.wr_addr)) ?
                       wr_merged_s : rd_val_s[p];
`else
         rd_val_s[p] = rd_val_s[p];
`endif
      end
   end

   // Clear sequencer, storage update and registered read ports.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= INIT;
         clr_idx_r <= {AW{1'b0}};
         rd_data_r <= {(NRD*DATA_W){1'b0}};
         ready_r   <= 1'b0;
      end else begin
         case (state_r)
            INIT: begin
               regs_r[clr_idx_r] <= {DATA_W{1'b0}};
               rd_data_r         <= {(NRD*DATA_W){1'b0}};
               if (clr_idx_r == AW'(NUM_REGS - 1)) begin
                  state_r <= RUN;
                  ready_r <= 1'b1;
               end else begin
                  clr_idx_r <= clr_idx_r + {{(AW-1){1'b0}}, 1'b1};
                  ready_r   <= 1'b0;
               end
            end
            RUN: begin
               ready_r <= 1'b1;
               if (wr_hit_s) begin
                  regs_r[bus.wr_addr] <= wr_merged_s;
               end
               for (int p = 0; p < NRD; p++) begin
                  if (bus.rd_en[p]) begin
                     rd_data_r[p*DATA_W +: DATA_W] <= rd_val_s[p];
                  end
               end
            end
            default: begin
               state_r   <= INIT;
               clr_idx_r <= {AW{1'b0}};
               rd_data_r <= {(NRD*DATA_W){1'b0}};
               ready_r   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rd_data = rd_data_r;
   assign bus.ready   = ready_r;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: default 32x32/2-port instance plus a 16-bit,
// 12-entry, 3-port instance; follows REGFILE_BYPASS_EN for collision expectations.
module tb_regfile_mp;

   localparam int NR  = 32;
   localparam int NRB = 12;

   typedef struct {
      int          port;
      logic [31:0] exp;
      string       tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic rst_b;
   always #5 clk = ~clk;

   regfile_mp_if #(.DATA_W(32), .NUM_REGS(NR),  .NRD(2)) bus_a ();
   regfile_mp_if #(.DATA_W(16), .NUM_REGS(NRB), .NRD(3)) bus_b ();

   regfile_mp #(.DATA_W(32), .NUM_REGS(NR), .NRD(2)) dut_a (
      .clk (clk), .rst (rst), .bus (bus_a)
   );
   regfile_mp #(.DATA_W(16), .NUM_REGS(NRB), .NRD(3)) dut_b (
      .clk (clk), .rst (rst_b), .bus (bus_b)
   );

   int          errors = 0;
   int          checks = 0;
   logic [31:0] model_a [NR];
   logic [15:0] model_b [NRB];
   logic [31:0] held_a  [2];
   logic [15:0] held_b  [3];
   exp_t        sb_q [$];

   function automatic logic [31:0] merge32(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] be);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? n[8*i +: 8] : o[8*i +: 8];
      return r;
   endfunction

   task automatic do_cycle_a(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                             input logic [3:0] be, input logic [1:0] re,
                             input logic [4:0] ra0, input logic [4:0] ra1, input string tag);
      logic [4:0]  ra [2];
      logic [31:0] e;
      exp_t        x;
      ra[0] = ra0;
      ra[1] = ra1;
      bus_a.wr_en = we; bus_a.wr_addr = wa; bus_a.wr_data = wd; bus_a.wr_be = be;
      bus_a.rd_en = re; bus_a.rd_addr = {ra1, ra0};
      for (int p = 0; p < 2; p++) begin
         if (re[p]) begin
            e = (ra[p] == 5'd0) ? 32'd0 : model_a[ra[p]];
`ifdef REGFILE_BYPASS_EN
            if (we && wa != 5'd0 && wa == ra[p]) e = merge32(model_a[wa], wd, be);
`endif
            held_a[p] = e;
         end
         sb_q.push_back('{port: p, exp: held_a[p], tag: tag});
      end
      @(posedge clk);
      if (we && wa != 5'd0) model_a[wa] = merge32(model_a[wa], wd, be);
      @(negedge clk);
      while (sb_q.size() > 0) begin
         x = sb_q.pop_front();
         checks++;
         if (bus_a.rd_data[x.port*32 +: 32] !== x.exp) begin
            errors++;
            $display("FAIL %s port%0d: got %h expected %h", x.tag, x.port,
                     bus_a.rd_data[x.port*32 +: 32], x.exp);
         end
      end
      bus_a.wr_en = 1'b0;
      bus_a.rd_en = 2'b00;
   endtask

   task automatic do_cycle_b(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                             input logic [1:0] be, input logic [2:0] re, input logic [3:0] ra0,
                             input logic [3:0] ra1, input logic [3:0] ra2, input string tag);
      logic [3:0]  ra [3];
      logic [15:0] e;
      exp_t        x;
      ra[0] = ra0; ra[1] = ra1; ra[2] = ra2;
      bus_b.wr_en = we; bus_b.wr_addr = wa; bus_b.wr_data = wd; bus_b.wr_be = be;
      bus_b.rd_en = re; bus_b.rd_addr = {ra2, ra1, ra0};
      for (int p = 0; p < 3; p++) begin
         if (re[p]) begin
            e = (ra[p] == 4'd0 || ra[p] >= 4'(NRB)) ? 16'd0 : model_b[ra[p]];
`ifdef REGFILE_BYPASS_EN
            if (we && wa != 4'd0 && wa < 4'(NRB) && wa == ra[p])
               e = 16'(merge32({16'd0, model_b[wa]}, {16'd0, wd}, {2'b00, be}));
`endif
            held_b[p] = e;
         end
         sb_q.push_back('{port: p, exp: {16'd0, held_b[p]}, tag: tag});
      end
      @(posedge clk);
      if (we && wa != 4'd0 && wa < 4'(NRB))
         model_b[wa] = 16'(merge32({16'd0, model_b[wa]}, {16'd0, wd}, {2'b00, be}));
      @(negedge clk);
      while (sb_q.size() > 0) begin
         x = sb_q.pop_front();
         checks++;
         if (bus_b.rd_data[x.port*16 +: 16] !== x.exp[15:0]) begin
            errors++;
            $display("FAIL %s port%0d: got %h expected %h", x.tag, x.port,
                     bus_b.rd_data[x.port*16 +: 16], x.exp[15:0]);
         end
      end
      bus_b.wr_en = 1'b0;
      bus_b.rd_en = 3'b000;
   endtask

   // One-cycle reset (optionally with a write to r4), then watch the clear sequence.
   task automatic reset_seq_a(input logic wr_with_rst, input string tag);
      @(negedge clk);
      rst = 1'b1;
      bus_a.wr_en = wr_with_rst; bus_a.wr_addr = 5'd4;
      bus_a.wr_data = 32'h0000_0009; bus_a.wr_be = 4'hF;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (bus_a.ready !== 1'b0) begin
         errors++; $display("FAIL %s_ready_drop: got %b expected 0", tag, bus_a.ready);
      end
      checks++;
      if (bus_a.rd_data !== 64'd0) begin
         errors++; $display("FAIL %s_rd_clear: got %h expected 0", tag, bus_a.rd_data);
      end
      bus_a.rd_en = 2'b11; bus_a.rd_addr = {5'd2, 5'd1};
      for (int i = 1; i <= NR; i++) begin
         bus_a.wr_en = (i < NR); bus_a.wr_addr = 5'd1;
         bus_a.wr_data = 32'hFFFF_FFFF; bus_a.wr_be = 4'hF;
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (bus_a.ready !== (i == NR)) begin
            errors++;
            $display("FAIL %s_ready_cyc%0d: got %b expected %b", tag, i, bus_a.ready, i == NR);
         end
         checks++;
         if (bus_a.rd_data !== 64'd0) begin
            errors++; $display("FAIL %s_init_rd_cyc%0d: got %h expected 0", tag, i, bus_a.rd_data);
         end
      end
      bus_a.wr_en = 1'b0; bus_a.rd_en = 2'b00;
      for (int i = 0; i < NR; i++) model_a[i] = 32'd0;
      held_a[0] = 32'd0; held_a[1] = 32'd0;
      for (int a = 0; a < 16; a++) do_cycle_a(1'b0, 5'd0, 32'd0, 4'h0, 2'b11, 5'(a), 5'(a + 16), {tag, "_zero"});
   endtask

   task automatic test_reset();
      reset_seq_a(1'b0, "reset");
   endtask

   task automatic test_byte_write();
      do_cycle_a(1'b1, 5'd5, 32'hAABB_CCDD, 4'hF, 2'b00, 5'd0, 5'd0, "bw_full");
      do_cycle_a(1'b1, 5'd5, 32'h0000_0011, 4'h1, 2'b00, 5'd0, 5'd0, "bw_lane0");
      do_cycle_a(1'b0, 5'd0, 32'd0, 4'h0, 2'b11, 5'd5, 5'd5, "bw_rd1");
      do_cycle_a(1'b1, 5'd5, 32'h0000_2233, 4'h3, 2'b00, 5'd0, 5'd0, "bw_lane01");
      do_cycle_a(1'b1, 5'd5, 32'h5555_5555, 4'h0, 2'b00, 5'd0, 5'd0, "bw_be0");
      do_cycle_a(1'b0, 5'd0, 32'd0, 4'h0, 2'b01, 5'd5, 5'd0, "bw_rd2");
      do_cycle_a(1'b0, 5'd0, 32'd0, 4'h0, 2'b00, 5'd0, 5'd0, "bw_hold");
   endtask

   task automatic test_zero_reg();
      do_cycle_a(1'b1, 5'd0, 32'hFFFF_FFFF, 4'hF, 2'b00, 5'd0, 5'd0, "r0_wr");
      do_cycle_a(1'b0, 5'd0, 32'd0, 4'h0, 2'b11, 5'd0, 5'd0, "r0_rd");
      do_cycle_a(1'b1, 5'd0, 32'hFFFF_FFFF, 4'hF, 2'b11, 5'd0, 5'd0, "r0_wr_rd");
   endtask

   task automatic test_collision();
      do_cycle_a(1'b1, 5'd7, 32'h1234_5678, 4'hF, 2'b00, 5'd0, 5'd0, "col_init");
      do_cycle_a(1'b1, 5'd7, 32'h0000_00EE, 4'h1, 2'b10, 5'd0, 5'd7, "col_same");
      do_cycle_a(1'b0, 5'd0, 32'd0, 4'h0, 2'b10, 5'd0, 5'd7, "col_next");
   endtask

   task automatic test_back_to_back();
      logic [4:0] wa;
      for (int i = 0; i < 80; i++) begin
         wa = 5'($urandom_range(0, NR - 1));
         do_cycle_a(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)),
                    2'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, NR - 1)),
                    ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, NR - 1)), "b2b");
      end
   endtask

   task automatic test_reset_mid_run();
      do_cycle_a(1'b1, 5'd3, 32'h0000_0005, 4'hF, 2'b00, 5'd0, 5'd0, "mid_wr3");
      do_cycle_a(1'b0, 5'd0, 32'd0, 4'h0, 2'b01, 5'd3, 5'd0, "mid_rd3");
      reset_seq_a(1'b1, "mid_reset");
   endtask

   task automatic test_params();
      @(negedge clk);
      rst_b = 1'b0;
      for (int i = 1; i <= NRB; i++) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (bus_b.ready !== (i == NRB)) begin
            errors++;
            $display("FAIL p_ready_cyc%0d: got %b expected %b", i, bus_b.ready, i == NRB);
         end
      end
      for (int i = 0; i < NRB; i++) model_b[i] = 16'd0;
      for (int i = 0; i < 3; i++) held_b[i] = 16'd0;
      do_cycle_b(1'b1, 4'd5, 16'hBEEF, 2'b11, 3'b000, 4'd0, 4'd0, 4'd0, "p_wr5");
      do_cycle_b(1'b1, 4'd13, 16'hFFFF, 2'b11, 3'b111, 4'd13, 4'd5, 4'd13, "p_wr13");
      do_cycle_b(1'b1, 4'd5, 16'h0012, 2'b01, 3'b010, 4'd0, 4'd5, 4'd0, "p_lane");
      do_cycle_b(1'b0, 4'd0, 16'd0, 2'b00, 3'b111, 4'd13, 4'd15, 4'd12, "p_oor_rd");
      for (int a = 0; a < NRB; a += 3)
         do_cycle_b(1'b0, 4'd0, 16'd0, 2'b00, 3'b111, 4'(a), 4'(a + 1), 4'(a + 2), "p_sweep");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      rst_b = 1'b1;
      bus_a.rd_en = 2'b00; bus_a.rd_addr = 10'd0; bus_a.wr_en = 1'b0;
      bus_a.wr_addr = 5'd0; bus_a.wr_data = 32'd0; bus_a.wr_be = 4'h0;
      bus_b.rd_en = 3'b000; bus_b.rd_addr = 12'd0; bus_b.wr_en = 1'b0;
      bus_b.wr_addr = 4'd0; bus_b.wr_data = 16'd0; bus_b.wr_be = 2'b00;
      test_reset();
      test_byte_write();
      test_zero_reg();
      test_collision();
      test_back_to_back();
      test_reset_mid_run();
      test_params();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, data width in bits (multiple of 8).
REQ-002 The block SHALL have parameter NUM_REGS, default 32, register count (2..256).
REQ-003 The block SHALL have parameter NRD, default 2, number of read ports.
REQ-004 The block SHALL define local AW = clog2(NUM_REGS) and BE_W = DATA_W/8.
REQ-005 The block SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-006 The block SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-007 The block SHALL have port rd_en  in  NRD  per-port read strobe.
REQ-008 The block SHALL have port rd_addr  in  NRD*AW  packed read addresses, port p at [p*AW +: AW].
REQ-009 The block SHALL have port rd_data  out  NRD*DATA_W  packed registered read data.
REQ-010 The block SHALL have port wr_en  in  1  write strobe.
REQ-011 The block SHALL have port wr_addr  in  AW  write address.
REQ-012 The block SHALL have port wr_data  in  DATA_W  write data.
REQ-013 The block SHALL have port wr_be  in  BE_W  byte-lane write enables, bit i covers [8i+7:8i].
REQ-014 The block SHALL have port ready  out  1  high when init is done and access is allowed.

Function
REQ-015 The FSM SHALL have two states, INIT and RUN; INIT clears one register per cycle using counter clr_idx, 0..NUM_REGS-1.
REQ-016 INIT SHALL go to RUN on the cycle after clr_idx == NUM_REGS-1 is written, so ready rises exactly NUM_REGS cycles after rst deasserts.
REQ-017 In INIT, wr_en SHALL be ignored, rd_data SHALL hold 0, and ready SHALL be 0.
REQ-018 In RUN, when wr_en=1, each lane with wr_be[i]=1 SHALL be updated at the clock edge; lanes with wr_be[i]=0 SHALL keep their value.
REQ-019 A write SHALL be dropped when wr_addr==0 or wr_addr>=NUM_REGS.
REQ-020 Register 0 SHALL always read as 0.
REQ-021 Read latency SHALL be 1 cycle: rd_data port p SHALL update at the edge where rd_en[p]=1 and SHALL hold its value while rd_en[p]=0.
REQ-022 A read with rd_addr>=NUM_REGS SHALL return 0.
REQ-023 Multiple read ports SHALL be independent, and identical addresses on several ports SHALL be legal.
REQ-024 When a read and a write hit the same address in the same cycle, the result SHALL follow REQ-029/REQ-030.
REQ-025 wr_be=0 with wr_en=1 SHALL be a no-op.

Reset
REQ-026 When rst=1 at an edge, the FSM SHALL enter INIT, set clr_idx=0, and clear rd_data and ready to 0.
REQ-027 rst asserted mid-INIT or mid-RUN SHALL restart the clear sequence from index 0, and a write in the same cycle as rst SHALL be discarded.
REQ-028 Register contents SHALL be undefined only during INIT, and all registers SHALL be 0 when ready first rises.

Configuration
REQ-029 With REGFILE_BYPASS_EN defined, a same-cycle same-address read/write SHALL return the byte-merged new value (written lanes new, other lanes old), and the address-0 and out-of-range rules SHALL still apply.
REQ-030 Without REGFILE_BYPASS_EN, a same-cycle same-address read SHALL return the pre-write value, and the new value SHALL be visible from the next read.

Structure
REQ-031 Package regfile_pkg SHALL hold the state enum (INIT, RUN), a clog2 helper function, and the byte-merge function merge_be(old, new, be).
REQ-032 The storage array, init FSM and read ports SHALL live in regfile_mp.
REQ-033 The byte-lane merge SHALL be the single sub-module regfile_be_merge, shared by the write path and the bypass path.
REQ-034 No file I/O SHALL be used in synthesizable code.

Verification
REQ-035 Init: rst=1 for 1 cycle, then 0 -> ready=0 for 32 cycles, ready=1 on cycle 32; reads of addresses 0..31 return 0.
REQ-036 Byte write: write 0xAABBCCDD to r5 with be=1111, then 0x00000011 with be=0001 -> read r5 = 0xAABBCC11; be=0011 with 0x00002233 -> 0xAABB2233.
REQ-037 Zero register: write 0xFFFFFFFF to r0 with be=1111 -> both ports read r0 = 0.
REQ-038 Collision: r7=0x12345678; same cycle write 0x000000EE with be=0001 and read r7 on port 1 -> 0x123456EE with REGFILE_BYPASS_EN, 0x12345678 without; next read 0x123456EE in both builds.
REQ-039 Reset mid-run: r3=0x5; assert rst together with a write to r4 -> ready drops next cycle; after 32 cycles r3=0 and r4=0.
REQ-040 Parameter sweep: DATA_W=16, NUM_REGS=12, NRD=3 -> reading addr 13 returns 0, writing addr 13 changes nothing, and ready rises after 12 cycles.
